// File: rtl/audio_pkg.sv
// Shared constants, state encoding and saturation helper for the audio sample conditioner.
package audio_pkg;

   localparam int ADC_WIDTH = 12;
   localparam int PCM_WIDTH = 16;
   localparam int DC_SHIFT  = 8;

   typedef enum logic {
      MUTED = 1'b0,
      RUN   = 1'b1
   } state_e;

   // Clamp a 17-bit signed difference into the 16-bit PCM range.
   function automatic logic signed [PCM_WIDTH-1:0] sat16(input logic signed [PCM_WIDTH:0] v);
      if (v > 17'sd32767) begin
         sat16 = 16'sh7FFF;
      end else if (v < -17'sd32768) begin
         sat16 = 16'sh8000;
      end else begin
         sat16 = v[PCM_WIDTH-1:0];
      end
   endfunction

endpackage

// File: rtl/audio_sample_conditioner_if.sv
// Sample-in / PCM-out signal bundle; the ADC side is the master, the conditioner the slave.
interface audio_sample_conditioner_if;
   import audio_pkg::*;

   logic                 sample_valid;
   logic [ADC_WIDTH-1:0] adc_data;
   logic [PCM_WIDTH-1:0] pcm_out;
   logic                 pcm_strobe;
   logic                 adc_stalled;

   modport master (
      output sample_valid, adc_data,
      input  pcm_out, pcm_strobe, adc_stalled
   );

   modport slave (
      input  sample_valid, adc_data,
      output pcm_out, pcm_strobe, adc_stalled
   );

endinterface

// File: rtl/audio_dc_blocker.sv
// First-order DC blocker: y = sat16(x - dc_acc[23:8]), dc_acc tracks the input mean on each emit.
module audio_dc_blocker
   import audio_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        emit,
   input  logic signed [PCM_WIDTH-1:0] x,
   output logic signed [PCM_WIDTH-1:0] y
);

   localparam int DC_ACC_W = DC_SHIFT + PCM_WIDTH;

   logic signed [DC_ACC_W-1:0]  dc_acc_q;
   logic signed [DC_ACC_W-1:0]  dc_acc_d;
   logic signed [PCM_WIDTH-1:0] dc;
   logic signed [PCM_WIDTH:0]   diff;

   always_comb begin
      dc       = dc_acc_q[DC_SHIFT +: PCM_WIDTH];
      diff     = {x[PCM_WIDTH-1], x} - {dc[PCM_WIDTH-1], dc};
      y        = sat16(diff);
      dc_acc_d = dc_acc_q;
      // The accumulator only moves on real emits, so it holds across muted periods.
      if (emit) begin
         dc_acc_d = dc_acc_q + {{(DC_ACC_W-PCM_WIDTH-1){diff[PCM_WIDTH]}}, diff};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dc_acc_q <= '0;
      end else begin
         dc_acc_q <= dc_acc_d;
      end
   end

endmodule

// File: rtl/audio_sample_conditioner.sv
// Averages 2**DECIM_LOG2 ADC samples into left-justified PCM and mutes on ADC stall.
// Optional DC blocker on the PCM path is enabled by defining AUDIO_DC_BLOCK_EN.
module audio_sample_conditioner
   import audio_pkg::*;
#(
   parameter int DECIM_LOG2     = 2,
   parameter int TIMEOUT_CYCLES = 4096
)(
   input logic                       clk,
   input logic                       reset_n,
   audio_sample_conditioner_if.slave bus
);

   localparam int CNT_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int ACC_W  = ADC_WIDTH + DECIM_LOG2;
   localparam int IDLE_W = 16;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << DECIM_LOG2) - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic signed [ACC_W-1:0]     acc_q, acc_d;
   logic [IDLE_W-1:0]           idle_q, idle_d;
   logic [PCM_WIDTH-1:0]        pcm_q, pcm_d;
   logic                        strobe_q, strobe_d;

   logic signed [ADC_WIDTH-1:0] s;
   logic signed [ACC_W-1:0]     s_ext;
   logic signed [ACC_W-1:0]     sum;
   logic signed [ADC_WIDTH-1:0] avg;
   logic [PCM_WIDTH-1:0]        x_val;
   logic [PCM_WIDTH-1:0]        emit_value;
   logic                        group_done;
   logic                        timeout;

`ifdef AUDIO_DC_BLOCK_EN
   logic signed [PCM_WIDTH-1:0] dc_y;

   audio_dc_blocker u_dc_blocker (
      .clk     (clk),
      .reset_n (reset_n),
      .emit    (group_done),
      .x       (x_val),
      .y       (dc_y)
   );

   assign emit_value = dc_y;
`else
   assign emit_value = x_val;
`endif

   // Sample in a muted state starts a fresh group, so both states share the accumulate path.
   always_comb begin
      s          = {~bus.adc_data[ADC_WIDTH-1], bus.adc_data[ADC_WIDTH-2:0]};
      s_ext      = ACC_W'(s);
      sum        = acc_q + s_ext;
      avg        = ADC_WIDTH'(sum >>> DECIM_LOG2);
      x_val      = {avg, {(PCM_WIDTH-ADC_WIDTH){1'b0}}};
      group_done = bus.sample_valid && (cnt_q == CNT_LAST);
      timeout    = (state_q == RUN) && !bus.sample_valid && (idle_q == IDLE_LAST);

      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      pcm_d    = pcm_q;
      strobe_d = 1'b0;
      idle_d   = bus.sample_valid ? '0 :
                 (idle_q == {IDLE_W{1'b1}}) ? idle_q : idle_q + IDLE_W'(1);

      if (bus.sample_valid) begin
         state_d = RUN;
         if (group_done) begin
            acc_d    = '0;
            cnt_d    = '0;
            pcm_d    = emit_value;
            strobe_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (timeout) begin
         state_d  = MUTED;
         acc_d    = '0;
         cnt_d    = '0;
         pcm_d    = '0;
         strobe_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= MUTED;
         cnt_q    <= '0;
         acc_q    <= '0;
         idle_q   <= '0;
         pcm_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         idle_q   <= idle_d;
         pcm_q    <= pcm_d;
         strobe_q <= strobe_d;
      end
   end

   assign bus.pcm_out     = pcm_q;
   assign bus.pcm_strobe  = strobe_q;
   assign bus.adc_stalled = (state_q == MUTED);

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Self-checking bench for audio_sample_conditioner: table-driven groups plus timeout,
// coincidence and reset sequences, with a strobe scoreboard checking value and cycle.
module tb_audio_sample_conditioner;
   import audio_pkg::*;

   typedef struct packed {
      logic [3:0][ADC_WIDTH-1:0] smp;
      logic [PCM_WIDTH-1:0]      x;
   } vec_t;

   typedef struct {
      logic [PCM_WIDTH-1:0] pcm;
      int                   cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;

   int   vectors        = 0;
   int   miscompares    = 0;
   int   cyc            = 0;
   int   last_valid_cyc = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic monitor_on     = 1'b0;
   logic record_on      = 1'b0;
   logic signed [23:0] model_dc_acc = '0;
   logic signed [PCM_WIDTH-1:0] pcm_hist[$];

   audio_sample_conditioner_if bus_if ();

   audio_sample_conditioner #(
      .DECIM_LOG2     (2),
      .TIMEOUT_CYCLES (4096)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if.slave)
   );

   always #5 clk = ~clk;

   // Cycle index of the most recent rising edge; a strobe is due at the edge that captures its valid.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [ADC_WIDTH-1:0] data);
      bus_if.sample_valid = 1'b1;
      bus_if.adc_data     = data;
      @(posedge clk);
      #1;
      bus_if.sample_valid = 1'b0;
      last_valid_cyc      = cyc;
   endtask

   task automatic push_expect(input logic [PCM_WIDTH-1:0] x);
      exp_t e;
`ifdef AUDIO_DC_BLOCK_EN
      logic signed [PCM_WIDTH-1:0] dc;
      logic signed [PCM_WIDTH:0]   d;
      dc = model_dc_acc[23:8];
      d  = $signed({x[PCM_WIDTH-1], x}) - $signed({dc[PCM_WIDTH-1], dc});
      model_dc_acc = model_dc_acc + 24'(d);
      if (d > 17'sd32767)       e.pcm = 16'h7FFF;
      else if (d < -17'sd32768) e.pcm = 16'h8000;
      else                      e.pcm = d[PCM_WIDTH-1:0];
`else
      e.pcm = x;
`endif
      e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic push_timeout(input int due_cyc);
      exp_t e;
      e.pcm = '0;
      e.cyc = due_cyc;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic settle(input string name);
      repeat (3) @(posedge clk);
      #1;
      checkOutput(name, sb.size(), 0);
      sb.delete();
   endtask

   task automatic do_reset();
      reset_n             = 1'b0;
      bus_if.sample_valid = 1'b0;
      bus_if.adc_data     = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n      = 1'b1;
      model_dc_acc = '0;
      sb.delete();
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      checkOutput("reset_pcm_out", bus_if.pcm_out, 16'h0000);
      checkOutput("reset_pcm_strobe", bus_if.pcm_strobe, 1'b0);
      checkOutput("reset_adc_stalled", bus_if.adc_stalled, 1'b1);
   endtask

   // Every strobe must match the oldest expectation in value and cycle; muted output must read 0.
   always @(negedge clk) begin
      if (monitor_on) begin
         if (bus_if.adc_stalled === 1'b1) begin
            checkOutput("muted_pcm_zero", bus_if.pcm_out, 16'h0000);
         end
         if (bus_if.pcm_strobe !== 1'b0) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_strobe", bus_if.pcm_strobe, 1'b0);
            end else begin
               mon_e = sb.pop_front();
               checkOutput("pcm_value", bus_if.pcm_out, mon_e.pcm);
               checkOutput("strobe_cycle", cyc, mon_e.cyc);
               if (record_on) pcm_hist.push_back(bus_if.pcm_out);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t tbl[9];
      int   e0;

      // Expected x assumes DECIM_LOG2 = 2; leftmost sample is applied first.
      tbl[0] = '{smp: {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, x: 16'h7FF0};
      tbl[1] = '{smp: {12'h000, 12'h000, 12'h000, 12'h000}, x: 16'h8000};
      tbl[2] = '{smp: {12'h800, 12'h800, 12'h800, 12'h800}, x: 16'h0000};
      tbl[3] = '{smp: {12'h900, 12'h700, 12'h900, 12'h700}, x: 16'h0000};
      tbl[4] = '{smp: {12'h801, 12'h801, 12'h801, 12'h800}, x: 16'h0000};
      tbl[5] = '{smp: {12'h7FF, 12'h7FF, 12'h7FF, 12'h800}, x: 16'hFFF0};
      tbl[6] = '{smp: {12'hA00, 12'hA00, 12'h600, 12'h600}, x: 16'h0000};
      tbl[7] = '{smp: {12'hC00, 12'hC00, 12'hC00, 12'hC00}, x: 16'h4000};
      tbl[8] = '{smp: {12'h123, 12'h456, 12'h789, 12'hABC}, x: 16'hDEF0};

      do_reset();
      check_reset_state();
      monitor_on = 1'b1;

      for (int i = 0; i < 9; i++) begin
         for (int j = 3; j >= 0; j--) begin
            applyStimulus(tbl[i].smp[j]);
            checkOutput("stalled_after_valid", bus_if.adc_stalled, 1'b0);
            if (j > 0) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
            end
         end
         push_expect(tbl[i].x);
         settle("group_strobe_seen");
      end

      // Timeout after a complete group: mute strobe exactly 4096 cycles after the last valid.
      e0 = last_valid_cyc;
      push_timeout(e0 + 4096);
      wait_until(e0 + 4095);
      checkOutput("stalled_before_timeout", bus_if.adc_stalled, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("stalled_at_timeout", bus_if.adc_stalled, 1'b1);
      settle("timeout_strobe_seen");

      // Partial group of two then silence: only the zero mute strobe, never a data strobe.
      applyStimulus(12'hA00);
      applyStimulus(12'hA00);
      checkOutput("stalled_partial", bus_if.adc_stalled, 1'b0);
      push_timeout(last_valid_cyc + 4096);
      wait_until(last_valid_cyc + 4097);
      settle("partial_timeout_strobe");
      checkOutput("partial_muted", bus_if.adc_stalled, 1'b1);

      // Sample arriving on the timeout cycle wins and the group completes normally.
      applyStimulus(12'h900);
      wait_until(last_valid_cyc + 4095);
      applyStimulus(12'h900);
      checkOutput("coincide_not_stalled", bus_if.adc_stalled, 1'b0);
      applyStimulus(12'h900);
      applyStimulus(12'h900);
      push_expect(16'h1000);
      settle("coincide_group_strobe");
      checkOutput("coincide_still_running", bus_if.adc_stalled, 1'b0);

      // Reset mid-group drops the partial group; the next group must start from sample 0.
      applyStimulus(12'h000);
      applyStimulus(12'h000);
      do_reset();
      check_reset_state();
      for (int j = 0; j < 4; j++) applyStimulus(12'hFFF);
      push_expect(16'h7FF0);
      settle("post_reset_group");

`ifdef AUDIO_DC_BLOCK_EN
      do_reset();
      check_reset_state();
      pcm_hist.delete();
      record_on = 1'b1;
      for (int g = 0; g < 2048; g++) begin
         for (int j = 0; j < 4; j++) applyStimulus(12'hA00);
         push_expect(16'h2000);
      end
      settle("dc_stream_drained");
      record_on = 1'b0;
      checkOutput("dc_output_count", pcm_hist.size(), 2048);
      if (pcm_hist.size() == 2048) begin
         checkOutput("dc_first_output", pcm_hist[0], 16'h2000);
         for (int k = 1; k < 2048; k++) begin
            vectors++;
            if (pcm_hist[k] > pcm_hist[k-1]) begin
               miscompares++;
               $display("[TB] FAIL dc_monotonic: output %0d is %0d, previous %0d", k, pcm_hist[k], pcm_hist[k-1]);
            end
         end
         checkOutput("dc_settled", (pcm_hist[2047] < 16 && pcm_hist[2047] > -16), 1'b1);
      end
`endif

      checkOutput("final_scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
